// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side signals of the shared FIFO write port.
// Handshake: producer i transfers a word on any rising edge where
// req_valid[i] & req_ready[i]; req_data must stay stable while valid and not ready.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_full;
  logic                      fifo_wr;
  logic [DATA_W-1:0]         fifo_data_in;

  // Environment side: producers and the FIFO memory.
  modport master (
    output req_valid,
    output req_data,
    output fifo_full,
    input  req_ready,
    input  fifo_wr,
    input  fifo_data_in
  );

  // Arbiter side.
  modport slave (
    input  req_valid,
    input  req_data,
    input  fifo_full,
    output req_ready,
    output fifo_wr,
    output fifo_data_in
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter with burst locking in front of a single FIFO write port.
// One stage register decouples producer handshakes from the FIFO full flag.
module fifo_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  parameter int BURST   = 4,
  parameter int ID_W    = 2
) (
  input  logic            clk,
  input  logic            rst,
  fifo_wr_arbiter_if.slave bus,
  output logic [ID_W-1:0] grant_id,
  output logic            lock_active,
  output logic [15:0]     beats_written,
  output logic [0:0]      fsm_state,
  output logic [ID_W-1:0] rr_ptr
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam int         CNT_W     = 5;

  logic [0:0]        state;
  logic              stage_valid;
  logic [DATA_W-1:0] stage_data;
  logic [ID_W-1:0]   grant_id_q;
  logic [ID_W-1:0]   owner;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [CNT_W-1:0]  burst_cnt;
  logic [15:0]       beats_q;

  logic              fifo_wr;
  logic              load_en;
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   scan_idx;
  logic [NUM_REQ-1:0] grant_vec;
  logic              drop_lock;
  logic [DATA_W-1:0] grant_data;
  logic [CNT_W-1:0]  next_cnt;
  logic              burst_done;

  // Explicit wrap so non-power-of-two NUM_REQ never points past the last producer.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] i);
    if (i >= ID_W'(NUM_REQ - 1)) begin
      return '0;
    end
    return i + ID_W'(1);
  endfunction

  assign fifo_wr = stage_valid & ~bus.fifo_full;
  assign load_en = ~stage_valid | fifo_wr;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    drop_lock   = 1'b0;
    scan_idx    = rr_ptr_q;
    if (!rst && load_en) begin
      if (state == ST_LOCKED) begin
        if (bus.req_valid[owner]) begin
          grant_found = 1'b1;
          grant_idx   = owner;
        end else begin
          drop_lock = 1'b1;
        end
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!grant_found && bus.req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
          end
          scan_idx = wrap_inc(scan_idx);
        end
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    if (grant_found) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        grant_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // A grant from IDLE opens a new burst; a grant from LOCKED extends it.
  assign next_cnt   = (state == ST_LOCKED) ? burst_cnt + CNT_W'(1) : CNT_W'(1);
  assign burst_done = (next_cnt == CNT_W'(BURST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      stage_valid <= 1'b0;
      stage_data  <= '0;
      grant_id_q  <= '0;
      owner       <= '0;
      rr_ptr_q    <= '0;
      burst_cnt   <= '0;
      beats_q     <= '0;
    end else begin
      if (fifo_wr) begin
        beats_q <= beats_q + 16'd1;
      end
      if (grant_found) begin
        stage_valid <= 1'b1;
        stage_data  <= grant_data;
        grant_id_q  <= grant_idx;
        if (state == ST_IDLE) begin
          owner <= grant_idx;
        end
        if (burst_done) begin
          state     <= ST_IDLE;
          burst_cnt <= '0;
          rr_ptr_q  <= wrap_inc(grant_idx);
        end else begin
          state     <= ST_LOCKED;
          burst_cnt <= next_cnt;
        end
      end else begin
        if (fifo_wr) begin
          stage_valid <= 1'b0;
        end
        // Owner went quiet mid-burst: release and move priority past it.
        if (drop_lock) begin
          state     <= ST_IDLE;
          burst_cnt <= '0;
          rr_ptr_q  <= wrap_inc(owner);
        end
      end
    end
  end

  assign bus.req_ready    = grant_vec;
  assign bus.fifo_wr      = fifo_wr;
  assign bus.fifo_data_in = stage_data;
  assign grant_id         = grant_id_q;
  assign lock_active      = (state == ST_LOCKED);
  assign beats_written    = beats_q;
  assign fsm_state        = state;
  assign rr_ptr           = rr_ptr_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a BURST=4 instance with a FIFO occupancy model
// and a BURST=1 instance; a monitor scores every FIFO write against expected queues.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 64;
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();
  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus1 ();

  logic [IW-1:0] grant_id, grant_id1, rr_ptr, rr_ptr1;
  logic          lock_active, lock_active1;
  logic [15:0]   beats, beats1;
  logic [0:0]    fsm_state, fsm_state1;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .BURST(4), .ID_W(IW)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .grant_id(grant_id), .lock_active(lock_active),
    .beats_written(beats), .fsm_state(fsm_state), .rr_ptr(rr_ptr)
  );

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .BURST(1), .ID_W(IW)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .grant_id(grant_id1), .lock_active(lock_active1),
    .beats_written(beats1), .fsm_state(fsm_state1), .rr_ptr(rr_ptr1)
  );

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp1_q[$];
  int rem[NR];
  int seq[NR];
  int start[NR];
  int seq1[NR];
  int cyc;
  int tnum;
  int fifo_cnt;
  logic auto_rd, man_rd, overflow;
  logic [NR-1:0] fire, last_ready;
  logic last_wr, last_lock;
  logic [IW-1:0] last_rr;

  function automatic logic [DW-1:0] word(input int p, input int s);
    return {8'(p), 24'(tnum), 32'(s)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (bus.fifo_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %0h expected none", bus.fifo_data_in);
      end else begin
        e = exp_q.pop_front();
        check("wr_data", bus.fifo_data_in, e);
        check("wr_grant_id", 64'(grant_id), 64'(e[57:56]));
      end
    end
    if (bus1.fifo_wr === 1'b1) begin
      if (exp1_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write1: got %0h expected none", bus1.fifo_data_in);
      end else begin
        e = exp1_q.pop_front();
        check("wr1_data", bus1.fifo_data_in, e);
        check("wr1_grant_id", 64'(grant_id1), 64'(e[57:56]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive();
    for (int p = 0; p < NR; p++) begin
      bus.req_valid[p] = (rem[p] > 0) && (cyc >= start[p]);
      bus.req_data[p*DW +: DW] = word(p, seq[p]);
    end
  endtask

  // One clock: sample at negedge, then advance producers and the FIFO occupancy model.
  task automatic step();
    logic rd;
    @(negedge clk);
    fire       = bus.req_valid & bus.req_ready;
    last_ready = bus.req_ready;
    last_wr    = bus.fifo_wr;
    last_lock  = lock_active;
    last_rr    = rr_ptr;
    check("ready_onehot0", 64'($countones(bus.req_ready) <= 1), 64'd1);
    rd = (auto_rd || man_rd) && (fifo_cnt > 0);
    if (last_wr && bus.fifo_full) overflow = 1'b1;
    @(posedge clk);
    #1;
    fifo_cnt = fifo_cnt + (last_wr ? 1 : 0) - (rd ? 1 : 0);
    bus.fifo_full = (fifo_cnt >= 16);
    for (int p = 0; p < NR; p++) begin
      if (fire[p]) begin
        seq[p]++;
        rem[p]--;
      end
    end
    cyc++;
    drive();
  endtask

  task automatic setup(input int t);
    tnum = t;
    for (int p = 0; p < NR; p++) begin
      rem[p] = 0; seq[p] = 0; start[p] = 0; seq1[p] = 0;
    end
    cyc = 0; fifo_cnt = 0; auto_rd = 1'b1; man_rd = 1'b0;
    bus.fifo_full = 1'b0;
    bus1.req_valid = '0;
    drive();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string name, input int max);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < max) begin
      step();
      k++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int ok, wrs;
    logic [NR-1:0] g;
    overflow = 1'b0;
    bus1.fifo_full = 1'b0;
    bus1.req_valid = '0;
    bus1.req_data  = '0;
    bus.fifo_full  = 1'b0;
    bus.req_valid  = '1;
    bus.req_data   = '0;
    rst = 1'b1;
    #1;
    check("rst_fifo_wr", 64'(bus.fifo_wr), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);
    check("rst_lock", 64'(lock_active), 64'd0);
    check("rst_beats", 64'(beats), 64'd0);
    check("rst_rr_ptr", 64'(rr_ptr), 64'd0);
    @(posedge clk);
    #1;

    // T1: single producer streams 20 words
    setup(1);
    rem[0] = 20;
    for (int s = 0; s < 20; s++) exp_q.push_back(word(0, s));
    drive();
    ok = 0; wrs = 0;
    for (int n = 0; n < 21; n++) begin
      step();
      if (n < 20 && fire[0]) ok++;
      if (n >= 1 && last_wr) wrs++;
    end
    check("t1_ready_every_cycle", 64'(ok), 64'd20);
    check("t1_wr_continuous", 64'(wrs), 64'd20);
    check("t1_beats", 64'(beats), 64'd20);
    drain("t1_drain", 10);

    // T2: all four valid, bursts of 4 rotate 0,1,2,3
    setup(2);
    for (int p = 0; p < NR; p++) rem[p] = 8;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NR; p++)
        for (int s = 0; s < 4; s++) exp_q.push_back(word(p, r*4 + s));
    drive();
    for (int n = 0; n < 32; n++) begin
      step();
      g = 4'b0001 << ((n / 4) % 4);
      check("t2_grant", 64'(fire), 64'(g));
      check("t2_lock", 64'(last_lock), 64'((n % 4) != 0));
    end
    drain("t2_drain", 10);
    check("t2_beats", 64'(beats), 64'd32);

    // T3: BURST=1 instance, producers 1 and 3 alternate
    setup(3);
    for (int n = 0; n < 8; n++) exp1_q.push_back(word((n % 2 == 0) ? 1 : 3, n / 2));
    bus1.req_valid = 4'b1010;
    for (int n = 0; n < 8; n++) begin
      bus1.req_data[1*DW +: DW] = word(1, seq1[1]);
      bus1.req_data[3*DW +: DW] = word(3, seq1[3]);
      @(negedge clk);
      g = (n % 2 == 0) ? 4'b0010 : 4'b1000;
      check("t3_ready", 64'(bus1.req_ready), 64'(g));
      for (int p = 0; p < NR; p++) if (bus1.req_ready[p] && bus1.req_valid[p]) seq1[p]++;
      @(posedge clk);
      #1;
    end
    bus1.req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    check("t3_drain", 64'(exp1_q.size()), 64'd0);

    // T4: fill the FIFO with no reads, then release one slot
    setup(4);
    auto_rd = 1'b0;
    rem[0] = 18;
    for (int s = 0; s < 18; s++) exp_q.push_back(word(0, s));
    drive();
    wrs = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (last_wr) wrs++;
    end
    check("t4_writes_to_full", 64'(wrs), 64'd16);
    check("t4_full", 64'(bus.fifo_full), 64'd1);
    check("t4_ready_held", 64'(last_ready), 64'd0);
    check("t4_wr_held", 64'(last_wr), 64'd0);
    check("t4_stage_word", bus.fifo_data_in, word(0, 16));
    man_rd = 1'b1;
    step();
    man_rd = 1'b0;
    step();
    check("t4_held_word_writes", 64'(last_wr), 64'd1);
    check("t4_overflow", 64'(overflow), 64'd0);
    auto_rd = 1'b1;
    drain("t4_drain", 10);

    // T5: producer 2 locked, drops valid after 2 beats; producer 0 waiting
    setup(5);
    rem[2] = 2; rem[0] = 2; start[0] = 1;
    exp_q.push_back(word(2, 0));
    exp_q.push_back(word(2, 1));
    exp_q.push_back(word(0, 0));
    exp_q.push_back(word(0, 1));
    drive();
    for (int n = 0; n < 4; n++) begin
      step();
      if (n == 2) check("t5_no_grant", 64'(fire), 64'd0);
      if (n == 3) begin
        check("t5_idle_wr", 64'(last_wr), 64'd0);
        check("t5_idle_lock", 64'(last_lock), 64'd0);
        check("t5_rr_ptr", 64'(last_rr), 64'd3);
        check("t5_next_grant", 64'(fire), 64'b0001);
      end
    end
    drain("t5_drain", 10);

    // T6: reset mid-burst with a word in the stage
    setup(6);
    for (int p = 0; p < NR; p++) rem[p] = 4;
    exp_q.push_back(word(0, 0));
    exp_q.push_back(word(0, 1));
    exp_q.push_back(word(0, 3));
    for (int p = 1; p < NR; p++)
      for (int s = 0; s < 4; s++) exp_q.push_back(word(p, s));
    drive();
    repeat (3) step();
    rst = 1'b1;
    #1;
    check("t6_rst_fifo_wr", 64'(bus.fifo_wr), 64'd0);
    check("t6_rst_ready", 64'(bus.req_ready), 64'd0);
    check("t6_rst_grant_id", 64'(grant_id), 64'd0);
    check("t6_rst_lock", 64'(lock_active), 64'd0);
    check("t6_rst_beats", 64'(beats), 64'd0);
    check("t6_rst_data", bus.fifo_data_in, 64'd0);
    step();
    check("t6_rst_cycle_ready", 64'(last_ready), 64'd0);
    check("t6_rst_cycle_wr", 64'(last_wr), 64'd0);
    rst = 1'b0;
    step();
    check("t6_restart_grant", 64'(fire), 64'b0001);
    drain("t6_drain", 40);
    check("t6_beats", 64'(beats), 64'd13);
    check("final_overflow", 64'(overflow), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
